// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a WIDTH-bit pattern out MSB first, (count+1) times back to back.
// Optional build macro SERIAL_PATTERN_TX_PARITY_EN appends one even-parity bit after each pattern.
module serial_pattern_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       count,
  output logic             x,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

`ifdef SERIAL_PATTERN_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, PAR, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [2:0]       rep_q, rep_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic             x_q, x_d;
  logic             last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      pat_q   <= '0;
      rep_q   <= '0;
      bit_q   <= '0;
      x_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      pat_q   <= pat_d;
      rep_q   <= rep_d;
      bit_q   <= bit_d;
      x_q     <= x_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    pat_d   = pat_q;
    rep_d   = rep_q;
    bit_d   = bit_q;
    x_d     = x_q;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        x_d = 1'b0;
        if (start) begin
          pat_d   = data;
          rep_d   = count;
          x_d     = data[WIDTH-1];
          shreg_d = {data[WIDTH-2:0], 1'b0};
          bit_d   = CW'(WIDTH-1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (bit_q != '0) begin
          x_d     = shreg_q[WIDTH-1];
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          bit_d   = bit_q - CW'(1);
        end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
          state_d = PAR;
          x_d     = ^pat_q;
`else
          last    = 1'b1;
`endif
        end
      end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
      PAR:     last = 1'b1;
`endif
      DONE: begin
        x_d     = 1'b0;
        state_d = IDLE;
      end
      default: begin
        x_d     = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Pattern boundary: reload with no gap while repetitions remain, else finish.
    if (last) begin
      if (rep_q != 3'd0) begin
        rep_d   = rep_q - 3'd1;
        x_d     = pat_q[WIDTH-1];
        shreg_d = {pat_q[WIDTH-2:0], 1'b0};
        bit_d   = CW'(WIDTH-1);
        state_d = SEND;
      end else begin
        x_d     = 1'b0;
        state_d = DONE;
      end
    end
  end

  assign x    = x_q;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
  assign busy = (state_q == SEND) || (state_q == PAR);
`else
  assign busy = (state_q == SEND);
`endif
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed bench for serial_pattern_tx (WIDTH=4); expectations follow SERIAL_PATTERN_TX_PARITY_EN.
module tb_serial_pattern_tx;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [3:0] data;
  logic [2:0] count;
  logic       x, busy, done;
  int         nvec = 0;
  int         nerr = 0;

  serial_pattern_tx #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .count(count),
    .x(x), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp);
    nvec++;
    assert ({x, busy, done} === exp)
      else begin
        nerr++;
        $error("FAIL %s: {x,busy,done} observed %b expected %b", tag, {x, busy, done}, exp);
      end
  endtask

  // Checks n burst bits (MSB of bits[n-1:0] first), then the done cycle.
  task automatic burst(input string tag, input logic [63:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      chk(tag, {bits[n-1-i], 1'b1, 1'b0});
      tick();
    end
    chk({tag, "_done"}, 3'b001);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data = '0; count = '0;
    tick(); tick();
    chk("reset", 3'b000);
    reset = 1'b0;
    tick();
    chk("idle", 3'b000);

    // Basic single pattern
    start = 1'b1; data = 4'b1000; count = 3'd0;
    tick();
    start = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    burst("basic", 64'b10001, 5);
`else
    burst("basic", 64'b1000, 4);
`endif
    tick();
    chk("idle_after_basic", 3'b000);

    // Repetitions, with start held and data/count changed mid-burst
    start = 1'b1; data = 4'b1000; count = 3'd2;
    tick();
    data = 4'b0111; count = 3'd5;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    burst("reps", {3{5'b10001}}, 15);
`else
    burst("reps", {3{4'b1000}}, 12);
`endif
    // start still high during DONE must be ignored
    tick();
    chk("start_in_done", 3'b000);
    // start in the first idle cycle after DONE is accepted
    data = 4'b0110; count = 3'd1;
    tick();
    start = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    burst("back2back", {2{5'b01100}}, 10);
`else
    burst("back2back", {2{4'b0110}}, 8);
`endif
    tick();
    chk("idle_after_b2b", 3'b000);

    // Maximum repetition count
    start = 1'b1; data = 4'b1101; count = 3'd7;
    tick();
    start = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    burst("count7", {8{5'b11011}}, 40);
`else
    burst("count7", {8{4'b1101}}, 32);
`endif
    tick();
    chk("idle_after_count7", 3'b000);

    // Parity patterns (plain patterns in the default build)
    start = 1'b1; data = 4'b1011; count = 3'd0;
    tick();
    start = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    burst("par1011", 64'b10111, 5);
`else
    burst("pat1011", 64'b1011, 4);
`endif
    tick();
    start = 1'b1; data = 4'b1001;
    tick();
    start = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    burst("par1001", 64'b10010, 5);
`else
    burst("pat1001", 64'b1001, 4);
`endif
    tick();

    // Reset abort while bit 2 of 1010 is on x
    start = 1'b1; data = 4'b1010; count = 3'd3;
    tick();
    start = 1'b0;
    chk("abort_b0", 3'b110);
    tick();
    chk("abort_b1", 3'b010);
    tick();
    chk("abort_b2", 3'b110);
    reset = 1'b1;
    tick();
    chk("abort_reset", 3'b000);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abort_no_done", 3'b000);
    end

    // reset and start together: start discarded
    reset = 1'b1; start = 1'b1; data = 4'b1111; count = 3'd0;
    tick();
    chk("rst_start", 3'b000);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_idle", 3'b000);

    // Controller still usable after the abort
    start = 1'b1; data = 4'b0101; count = 3'd0;
    tick();
    start = 1'b0;
`ifdef SERIAL_PATTERN_TX_PARITY_EN
    burst("post_abort", 64'b01010, 5);
`else
    burst("post_abort", 64'b0101, 4);
`endif
    tick();
    chk("final_idle", 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
